ysyx_041461_mem_lsu: RTL and testbench



---
 rtl/ysyx_041461_mem_lsu.sv | 169 ++++++++++++++++
 tb/tb_ysyx_041461_mem_lsu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_mem_lsu.sv
// MEM-stage load/store unit: issues one valid/ready data-memory access per MEM op and returns
// aligned, extended load data. Optional misalignment trap: YSYX_041461_LSU_MISALIGN_EN.
module ysyx_041461_mem_lsu #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned XLEN   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3:0]        in_mem_ctrl,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic              advance,
   output logic              lsu_stall,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_rdata,
   output logic              misalign_ld,
   output logic              misalign_st,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic              dmem_wen,
   output logic [63:0]       dmem_wdata,
   output logic [7:0]        dmem_wmask,
   input  logic              dmem_resp_valid,
   input  logic [63:0]       dmem_rdata
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q;
   logic [2:0]  off_q;

   logic        is_ld, is_st, is_mem, misalign;
   logic [1:0]  size;
   logic [2:0]  off;
   logic [7:0]  size_mask, wmask_n;
   logic [63:0] wdata64, wdata_n, rsh, ld_res;

   assign off     = in_addr[2:0];
   assign wdata64 = 64'(in_wdata);

   always_comb begin
      is_ld     = 1'b0;
      is_st     = 1'b0;
      size      = 2'd0;
      unique case (in_mem_ctrl)
         4'b0001, 4'b0101: begin is_ld = 1'b1; size = 2'd0; end
         4'b0010, 4'b0110: begin is_ld = 1'b1; size = 2'd1; end
         4'b0011, 4'b0111: begin is_ld = 1'b1; size = 2'd2; end
         4'b0100:          begin is_ld = 1'b1; size = 2'd3; end
         4'b1000:          begin is_st = 1'b1; size = 2'd0; end
         4'b1001:          begin is_st = 1'b1; size = 2'd1; end
         4'b1010:          begin is_st = 1'b1; size = 2'd2; end
         4'b1011:          begin is_st = 1'b1; size = 2'd3; end
         default: ;
      endcase
   end

   assign is_mem = in_valid & (is_ld | is_st);

   always_comb begin
      size_mask = 8'h01;
      case (size)
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         2'd3:    size_mask = 8'hFF;
         default: size_mask = 8'h01;
      endcase
   end

   // Shifts truncate to the 8-byte lane; bytes past bit 63 are dropped.
   assign wmask_n = size_mask << off;
   assign wdata_n = wdata64 << {off, 3'b000};

`ifdef YSYX_041461_LSU_MISALIGN_EN
   assign misalign = ((size == 2'd1) & off[0]) |
                     ((size == 2'd2) & (|off[1:0])) |
                     ((size == 2'd3) & (|off));
`else
   assign misalign = 1'b0;
`endif

   assign rsh = dmem_rdata >> {off_q, 3'b000};

   always_comb begin
      ld_res = 64'd0;
      case (op_q)
         4'b0001: ld_res = {{56{rsh[7]}}, rsh[7:0]};
         4'b0010: ld_res = {{48{rsh[15]}}, rsh[15:0]};
         4'b0011: ld_res = {{32{rsh[31]}}, rsh[31:0]};
         4'b0100: ld_res = rsh;
         4'b0101: ld_res = {56'd0, rsh[7:0]};
         4'b0110: ld_res = {48'd0, rsh[15:0]};
         4'b0111: ld_res = {32'd0, rsh[31:0]};
         default: ld_res = 64'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (is_mem) state_d = misalign ? StDone : StReq;
         StReq:  if (dmem_req_ready) state_d = StWait;
         StWait: if (dmem_resp_valid) state_d = StDone;
         StDone: if (advance) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   assign lsu_stall = (state_q == StReq) | (state_q == StWait) | ((state_q == StIdle) & is_mem);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q           <= 4'd0;
         off_q          <= 3'd0;
         out_valid      <= 1'b0;
         out_rdata      <= '0;
         misalign_ld    <= 1'b0;
         misalign_st    <= 1'b0;
         dmem_req_valid <= 1'b0;
         dmem_addr      <= '0;
         dmem_wen       <= 1'b0;
         dmem_wdata     <= 64'd0;
         dmem_wmask     <= 8'd0;
      end else begin
         case (state_q)
            StIdle: begin
               if (is_mem && misalign) begin
                  out_valid   <= 1'b1;
                  out_rdata   <= '0;
                  misalign_ld <= is_ld;
                  misalign_st <= is_st;
               end else if (is_mem) begin
                  op_q           <= in_mem_ctrl;
                  off_q          <= off;
                  dmem_req_valid <= 1'b1;
                  dmem_addr      <= {in_addr[ADDR_W-1:3], 3'b000};
                  dmem_wen       <= is_st;
                  dmem_wdata     <= is_st ? wdata_n : 64'd0;
                  dmem_wmask     <= wmask_n;
               end
            end
            StReq: if (dmem_req_ready) dmem_req_valid <= 1'b0;
            StWait: begin
               if (dmem_resp_valid) begin
                  out_valid <= 1'b1;
                  out_rdata <= XLEN'(ld_res);
               end
            end
            StDone: begin
               if (advance) begin
                  out_valid   <= 1'b0;
                  misalign_ld <= 1'b0;
                  misalign_st <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_041461_mem_lsu.sv
// Directed self-checking bench for ysyx_041461_mem_lsu (covers both settings of
// YSYX_041461_LSU_MISALIGN_EN).
module tb_ysyx_041461_mem_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_mem_ctrl;
   logic [63:0] in_addr;
   logic [63:0] in_wdata;
   logic        advance;
   logic        lsu_stall;
   logic        out_valid;
   logic [63:0] out_rdata;
   logic        misalign_ld;
   logic        misalign_st;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [63:0] dmem_addr;
   logic        dmem_wen;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wmask;
   logic        dmem_resp_valid;
   logic [63:0] dmem_rdata;

   int n_cmp = 0;
   int n_err = 0;
   int hs_cnt = 0;
   int hs_base;

   ysyx_041461_mem_lsu dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_mem_ctrl     (in_mem_ctrl),
      .in_addr         (in_addr),
      .in_wdata        (in_wdata),
      .advance         (advance),
      .lsu_stall       (lsu_stall),
      .out_valid       (out_valid),
      .out_rdata       (out_rdata),
      .misalign_ld     (misalign_ld),
      .misalign_st     (misalign_st),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_addr       (dmem_addr),
      .dmem_wen        (dmem_wen),
      .dmem_wdata      (dmem_wdata),
      .dmem_wmask      (dmem_wmask),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_rdata      (dmem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dmem_req_valid && dmem_req_ready) hs_cnt <= hs_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one aligned op from IDLE through to DONE; leaves the DUT in DONE.
   task automatic run_op(input string tag, input logic [3:0] ctrl, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata, input int nready,
                         input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                         input logic [7:0] exp_wmask, input logic [63:0] exp_out);
      hs_base     = hs_cnt;
      in_valid    = 1'b1;
      in_mem_ctrl = ctrl;
      in_addr     = addr;
      in_wdata    = wdata;
      dmem_req_ready = 1'b0;
      #1;
      check_eq({tag, ".stall_detect"}, 64'(lsu_stall), 64'd1);
      check_eq({tag, ".noreq_detect"}, 64'(dmem_req_valid), 64'd0);
      tick();
      for (int i = 0; i <= nready; i++) begin
         dmem_req_ready = (i == nready);
         #1;
         check_eq({tag, ".req_valid"}, 64'(dmem_req_valid), 64'd1);
         check_eq({tag, ".stall_req"}, 64'(lsu_stall), 64'd1);
         check_eq({tag, ".addr"}, dmem_addr, exp_addr);
         check_eq({tag, ".wen"}, 64'(dmem_wen), 64'(ctrl[3]));
         if (ctrl[3]) begin
            check_eq({tag, ".wdata"}, dmem_wdata, exp_wdata);
            check_eq({tag, ".wmask"}, 64'(dmem_wmask), 64'(exp_wmask));
         end
         tick();
      end
      dmem_req_ready = 1'b0;
      check_eq({tag, ".req_drop"}, 64'(dmem_req_valid), 64'd0);
      check_eq({tag, ".stall_wait"}, 64'(lsu_stall), 64'd1);
      check_eq({tag, ".handshakes"}, 64'(hs_cnt - hs_base), 64'd1);
      dmem_resp_valid = 1'b1;
      dmem_rdata      = rdata;
      tick();
      dmem_resp_valid = 1'b0;
      dmem_rdata      = 64'hDEAD_DEAD_DEAD_DEAD;
      check_eq({tag, ".out_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, ".out_rdata"}, out_rdata, exp_out);
      check_eq({tag, ".stall_done"}, 64'(lsu_stall), 64'd0);
      check_eq({tag, ".mis_ld"}, 64'(misalign_ld), 64'd0);
      check_eq({tag, ".mis_st"}, 64'(misalign_st), 64'd0);
   endtask

   task automatic finish_op(input string tag);
      advance  = 1'b1;
      in_valid = 1'b0;
      tick();
      advance  = 1'b0;
      check_eq({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, ".idle_stall"}, 64'(lsu_stall), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_mem_ctrl = 4'd0;
      in_addr = 64'd0;
      in_wdata = 64'd0;
      advance = 1'b0;
      dmem_req_ready = 1'b0;
      dmem_resp_valid = 1'b0;
      dmem_rdata = 64'd0;
      tick();
      tick();
      check_eq("rst.out_valid", 64'(out_valid), 64'd0);
      check_eq("rst.out_rdata", out_rdata, 64'd0);
      check_eq("rst.req_valid", 64'(dmem_req_valid), 64'd0);
      check_eq("rst.addr", dmem_addr, 64'd0);
      check_eq("rst.wmask", 64'(dmem_wmask), 64'd0);
      check_eq("rst.stall", 64'(lsu_stall), 64'd0);
      rst = 1'b0;
      tick();

      // LW sign-extension, then hold in DONE with in_valid still high.
      run_op("lw", 4'b0011, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 0,
             64'h8000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_8000_0001);
      hs_base = hs_cnt;
      for (int i = 0; i < 2; i++) begin
         tick();
         check_eq("hold.out_valid", 64'(out_valid), 64'd1);
         check_eq("hold.out_rdata", out_rdata, 64'hFFFF_FFFF_8000_0001);
         check_eq("hold.no_req", 64'(dmem_req_valid), 64'd0);
      end
      check_eq("hold.no_handshake", 64'(hs_cnt - hs_base), 64'd0);
      finish_op("lw");

      run_op("lwu", 4'b0111, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 0,
             64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_8000_0001);
      finish_op("lwu");
      run_op("sb", 4'b1000, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'hFFFF_FFFF_FFFF_FFFF, 0,
             64'h8000_0000, 64'h0000_0000_AB00_0000, 8'h08, 64'd0);
      finish_op("sb");
      run_op("ld_bp", 4'b0100, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 3,
             64'h8000_0010, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF);
      finish_op("ld_bp");
      run_op("lb", 4'b0001, 64'h8000_0007, 64'd0, 64'h8500_0000_0000_0000, 0,
             64'h8000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF85);
      finish_op("lb");
      run_op("lbu", 4'b0101, 64'h8000_0006, 64'd0, 64'h0012_3456_789A_BCDE, 1,
             64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_0000_0012);
      finish_op("lbu");
      run_op("lh", 4'b0010, 64'h8000_0002, 64'd0, 64'h0000_0000_F00D_BEEF, 0,
             64'h8000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_F00D);
      finish_op("lh");
      run_op("lhu", 4'b0110, 64'h8000_0002, 64'd0, 64'h0000_0000_F00D_BEEF, 0,
             64'h8000_0000, 64'd0, 8'h00, 64'h0000_0000_0000_F00D);
      finish_op("lhu");
      run_op("sd", 4'b1011, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 0,
             64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0);
      finish_op("sd");
      run_op("sh", 4'b1001, 64'h8000_0006, 64'hFFFF_FFFF_FFFF_BEEF, 64'd0, 2,
             64'h8000_0000, 64'hBEEF_0000_0000_0000, 8'hC0, 64'd0);
      finish_op("sh");
      run_op("sw", 4'b1010, 64'h8000_0004, 64'h0000_0000_DEAD_BEEF, 64'd0, 0,
             64'h8000_0000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'd0);
      finish_op("sw");

`ifdef YSYX_041461_LSU_MISALIGN_EN
      hs_base = hs_cnt;
      in_valid = 1'b1; in_mem_ctrl = 4'b0010; in_addr = 64'h8000_0001;
      #1;
      check_eq("mis_lh.stall", 64'(lsu_stall), 64'd1);
      tick();
      check_eq("mis_lh.no_req", 64'(dmem_req_valid), 64'd0);
      check_eq("mis_lh.out_valid", 64'(out_valid), 64'd1);
      check_eq("mis_lh.flag_ld", 64'(misalign_ld), 64'd1);
      check_eq("mis_lh.flag_st", 64'(misalign_st), 64'd0);
      check_eq("mis_lh.out_rdata", out_rdata, 64'd0);
      finish_op("mis_lh");
      check_eq("mis_lh.flag_clr", 64'(misalign_ld), 64'd0);
      in_valid = 1'b1; in_mem_ctrl = 4'b1010; in_addr = 64'h8000_0002;
      in_wdata = 64'h1122_3344;
      tick();
      check_eq("mis_sw.no_req", 64'(dmem_req_valid), 64'd0);
      check_eq("mis_sw.flag_st", 64'(misalign_st), 64'd1);
      check_eq("mis_sw.flag_ld", 64'(misalign_ld), 64'd0);
      finish_op("mis_sw");
      check_eq("mis.no_handshake", 64'(hs_cnt - hs_base), 64'd0);
`else
      run_op("mis_lh", 4'b0010, 64'h8000_0001, 64'd0, 64'h0000_0000_00AB_CD00, 0,
             64'h8000_0000, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_ABCD);
      finish_op("mis_lh");
      run_op("mis_sw", 4'b1010, 64'h8000_0002, 64'h0000_0000_1122_3344, 64'd0, 0,
             64'h8000_0000, 64'h0000_1122_3344_0000, 8'h3C, 64'd0);
      finish_op("mis_sw");
`endif

      // Non-memory codes and invalid slots must not stall or request.
      in_valid = 1'b1; in_mem_ctrl = 4'b0000; in_addr = 64'h8000_0000;
      #1;
      check_eq("nop.stall", 64'(lsu_stall), 64'd0);
      in_mem_ctrl = 4'b1100;
      #1;
      check_eq("bad_op.stall", 64'(lsu_stall), 64'd0);
      tick();
      check_eq("bad_op.no_req", 64'(dmem_req_valid), 64'd0);
      in_valid = 1'b0; in_mem_ctrl = 4'b0100;
      #1;
      check_eq("invalid.stall", 64'(lsu_stall), 64'd0);

      // Reset while waiting for a response; the late response must be ignored.
      in_valid = 1'b1; in_mem_ctrl = 4'b0100; in_addr = 64'h8000_0020;
      dmem_req_ready = 1'b1;
      tick();
      check_eq("rst_mid.req", 64'(dmem_req_valid), 64'd1);
      tick();
      dmem_req_ready = 1'b0;
      check_eq("rst_mid.wait_stall", 64'(lsu_stall), 64'd1);
      rst = 1'b1;
      in_valid = 1'b0;
      #1;
      check_eq("rst_mid.req_valid", 64'(dmem_req_valid), 64'd0);
      check_eq("rst_mid.addr", dmem_addr, 64'd0);
      check_eq("rst_mid.out_rdata", out_rdata, 64'd0);
      tick();
      rst = 1'b0;
      dmem_resp_valid = 1'b1;
      dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      dmem_resp_valid = 1'b0;
      tick();
      check_eq("late_resp.out_valid", 64'(out_valid), 64'd0);
      check_eq("late_resp.out_rdata", out_rdata, 64'd0);
      check_eq("late_resp.req_valid", 64'(dmem_req_valid), 64'd0);
      check_eq("late_resp.stall", 64'(lsu_stall), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
